axilite_user_arbiter: RTL

- Shares the single user-side command port of the AXI-Lite master between NUM_REQ requesters; one transaction in flight at a time.
- Arbitrates pending requests, latches the winner's command and sequences the master's user_start / user_free handshake.
- Returns read data and response status to the granted requester.
- Sits between client logic (DMA setup, register pokers) and the AXI-Lite master.

---
 rtl/axilite_user_arbiter_if.sv | 43 ++++
 rtl/axilite_user_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/axilite_user_arbiter_if.sv
// Signal bundle between the requesters, axilite_user_arbiter and the AXI-Lite master user port.
// The master modport is the arbiter's view; the slave modport is the surrounding logic's view.
interface axilite_user_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int STRB_W  = DATA_W / 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_w_r;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*STRB_W-1:0] req_strb;
    logic [NUM_REQ-1:0]        req_grant;
    logic [NUM_REQ-1:0]        req_done;
    logic [1:0]                req_status;
    logic [DATA_W-1:0]         req_rdata;
    logic                      arb_busy;

    logic                      user_start;
    logic                      user_w_r;
    logic [ADDR_W-1:0]         user_addr_in;
    logic [DATA_W-1:0]         user_data_in;
    logic [STRB_W-1:0]         user_data_strb;
    logic                      user_free;
    logic [1:0]                user_status;
    logic [DATA_W-1:0]         user_data_out;
    logic                      user_data_out_valid;

    modport master (
        input  req_valid, req_w_r, req_addr, req_data, req_strb,
        output req_grant, req_done, req_status, req_rdata, arb_busy,
        output user_start, user_w_r, user_addr_in, user_data_in, user_data_strb,
        input  user_free, user_status, user_data_out, user_data_out_valid
    );

    modport slave (
        output req_valid, req_w_r, req_addr, req_data, req_strb,
        input  req_grant, req_done, req_status, req_rdata, arb_busy,
        input  user_start, user_w_r, user_addr_in, user_data_in, user_data_strb,
        output user_free, user_status, user_data_out, user_data_out_valid
    );
endinterface

// File: rtl/axilite_user_arbiter.sv
// Shares the AXI-Lite master user port between NUM_REQ requesters, one transaction at a time.
// Define AXIL_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module axilite_user_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int STRB_W  = DATA_W / 8
) (
    input logic                   aclk,
    input logic                   aresetn,
    axilite_user_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

    state_t              state, state_next;
    logic [NUM_REQ-1:0]  win_onehot;
    logic                grant_load, rdata_capture, status_load;
    logic [NUM_REQ-1:0]  grant_q;
    logic                w_r_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [STRB_W-1:0]   strb_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [1:0]          status_q;
    logic                sel_w_r;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [STRB_W-1:0]   sel_strb;

`ifdef AXIL_ARB_FIXED_PRIO_EN
    always_comb begin
        win_onehot = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i]) begin
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
            end
        end
    end
`else
    logic [IDX_W-1:0] last_grant;

    // Indices above last_grant beat those at or below it, lowest first within each half.
    always_comb begin
        win_onehot = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (i <= int'(last_grant))) begin
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid[i] && (i > int'(last_grant))) begin
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_grant <= IDX_W'(NUM_REQ - 1);
        end else if (state == DONE) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_q[i]) last_grant <= IDX_W'(i);
            end
        end
    end
`endif

    always_comb begin
        sel_w_r  = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        sel_strb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                sel_w_r  = bus.req_w_r[i];
                sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_data = bus.req_data[i*DATA_W +: DATA_W];
                sel_strb = bus.req_strb[i*STRB_W +: STRB_W];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next     = state;
        grant_load     = 1'b0;
        rdata_capture  = 1'b0;
        status_load    = 1'b0;
        bus.user_start = (state == ISSUE);
        bus.arb_busy   = (state != IDLE);
        bus.req_grant  = grant_q;
        bus.req_done   = '0;
        bus.req_status = 2'b00;
        bus.req_rdata  = '0;
        unique case (state)
            IDLE: begin
                if (bus.user_free && (win_onehot != '0)) begin
                    grant_load = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!bus.user_free) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                rdata_capture = bus.user_data_out_valid && w_r_q;
                if (bus.user_free) begin
                    status_load = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                bus.req_done   = grant_q;
                bus.req_status = status_q;
                bus.req_rdata  = w_r_q ? rdata_q : '0;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // The command is frozen at grant so requester inputs can change freely mid-transaction.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant_q  <= '0;
            w_r_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            rdata_q  <= '0;
            status_q <= 2'b00;
        end else begin
            if (grant_load) begin
                grant_q <= win_onehot;
                w_r_q   <= sel_w_r;
                addr_q  <= sel_addr;
                data_q  <= sel_data;
                strb_q  <= sel_strb;
                rdata_q <= '0;
            end else if (state == DONE) begin
                grant_q <= '0;
            end
            if (rdata_capture) rdata_q  <= bus.user_data_out;
            if (status_load)   status_q <= bus.user_status;
        end
    end

    assign bus.user_w_r       = w_r_q;
    assign bus.user_addr_in   = addr_q;
    assign bus.user_data_in   = data_q;
    assign bus.user_data_strb = strb_q;
endmodule
